// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, MIPS opcode/funct
// constants, the issue-record type and small decode helpers.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_XOR = 4'd7;
    localparam logic [3:0] ALU_BEQ = 4'd8;
    localparam logic [3:0] ALU_BNE = 4'd9;
    localparam logic [3:0] ALU_NOP = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef struct packed {
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [3:0]      control;
        logic [4:0]      dest;
        logic            we;
        logic            mem_rd;
        logic            mem_wr;
        logic            mem_byte;
        logic [XLEN-1:0] store_data;
        logic            branch;
        logic            illegal;
    } issue_t;

    localparam issue_t ISSUE_IDLE = '{
        r1: '0, r2: '0, control: ALU_NOP, dest: '0, we: 1'b0, mem_rd: 1'b0,
        mem_wr: 1'b0, mem_byte: 1'b0, store_data: '0, branch: 1'b0, illegal: 1'b0
    };

    // Register-register funct codes; anything else maps to NOP.
    function automatic logic [3:0] funct_alu(input logic [5:0] funct);
        case (funct)
            F_ADD:   return ALU_ADD;
            F_SUB:   return ALU_SUB;
            F_AND:   return ALU_AND;
            F_OR:    return ALU_OR;
            F_XOR:   return ALU_XOR;
            F_SLT:   return ALU_SLT;
            F_SLL:   return ALU_SLL;
            F_SRL:   return ALU_SRL;
            default: return ALU_NOP;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu(input logic [5:0] opcode);
        case (opcode)
            OP_ADDI: return ALU_ADD;
            OP_SLTI: return ALU_SLT;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream (register read) and downstream (ALU/EX) handshake bundle of the issue stage.
// The issue stage itself takes the slave view; its neighbours take the master view.
interface alu_issue_if;
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [3:0]      control;
    logic [4:0]      dest;
    logic            we;
    logic            mem_rd;
    logic            mem_wr;
    logic            mem_byte;
    logic [XLEN-1:0] store_data;
    logic            branch;
    logic            illegal;

    modport slave (
        input  in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, r1, r2, control, dest, we,
               mem_rd, mem_wr, mem_byte, store_data, branch, illegal
    );

    modport master (
        output in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, r1, r2, control, dest, we,
               mem_rd, mem_wr, mem_byte, store_data, branch, illegal
    );
endinterface

// File: rtl/alu_decode.sv
// Combinational decoder: one MIPS-style instruction plus its register values
// become a complete issue record for the ALU and later stages.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs_val,
    input  logic [XLEN-1:0] i_rt_val,
    output issue_t          o_rec
);
    logic [5:0]      w_opcode;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [4:0]      w_shamt;
    logic [5:0]      w_funct;
    logic [XLEN-1:0] w_imm_sext;
    logic [XLEN-1:0] w_imm_zext;
    logic            w_unused_rs;

    assign w_opcode    = i_instr[31:26];
    assign w_rt        = i_instr[20:16];
    assign w_rd        = i_instr[15:11];
    assign w_shamt     = i_instr[10:6];
    assign w_funct     = i_instr[5:0];
    assign w_imm_sext  = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};
    assign w_imm_zext  = {{(XLEN-16){1'b0}}, i_instr[15:0]};
    // The rs index is resolved by register read; only its value arrives here.
    assign w_unused_rs = ^i_instr[25:21];

    always_comb begin
        o_rec = ISSUE_IDLE;
        case (w_opcode)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT: begin
                        o_rec.control = funct_alu(w_funct);
                        o_rec.r1      = i_rs_val;
                        o_rec.r2      = i_rt_val;
                        o_rec.dest    = w_rd;
                        o_rec.we      = 1'b1;
                    end
                    F_SLL, F_SRL: begin
                        o_rec.control = funct_alu(w_funct);
                        o_rec.r1      = i_rt_val;
                        o_rec.r2      = {{(XLEN-5){1'b0}}, w_shamt};
                        o_rec.dest    = w_rd;
                        o_rec.we      = 1'b1;
                    end
                    default: o_rec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                o_rec.control = imm_alu(w_opcode);
                o_rec.r1      = i_rs_val;
                o_rec.r2      = (w_opcode == OP_ADDI || w_opcode == OP_SLTI)
                                ? w_imm_sext : w_imm_zext;
                o_rec.dest    = w_rt;
                o_rec.we      = 1'b1;
            end
            OP_LB, OP_LW: begin
                o_rec.control  = ALU_ADD;
                o_rec.r1       = i_rs_val;
                o_rec.r2       = w_imm_sext;
                o_rec.dest     = w_rt;
                o_rec.we       = 1'b1;
                o_rec.mem_rd   = 1'b1;
                o_rec.mem_byte = (w_opcode == OP_LB);
            end
            OP_SB, OP_SW: begin
                o_rec.control    = ALU_ADD;
                o_rec.r1         = i_rs_val;
                o_rec.r2         = w_imm_sext;
                o_rec.mem_wr     = 1'b1;
                o_rec.mem_byte   = (w_opcode == OP_SB);
                o_rec.store_data = i_rt_val;
            end
            OP_BEQ, OP_BNE: begin
                o_rec.control = (w_opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                o_rec.r1      = i_rs_val;
                o_rec.r2      = i_rt_val;
                o_rec.branch  = 1'b1;
            end
            default: o_rec.illegal = 1'b1;
        endcase

        // Writes to $0 are suppressed, and a non-writing op never names a destination.
        if (o_rec.dest == 5'd0) o_rec.we = 1'b0;
        if (!o_rec.we) o_rec.dest = 5'd0;
    end
endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage in front of the ALU: decoder feeding a registered main
// output slot M backed by a skid slot S, with valid/ready on both sides and flush.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.slave  io
);
    issue_t w_dec;
    issue_t r_m;
    issue_t r_s;
    issue_t w_m_next;
    issue_t w_s_next;
    logic   r_m_valid;
    logic   r_s_valid;
    logic   r_in_ready;
    logic   w_m_valid_next;
    logic   w_s_valid_next;
    logic   w_accept;

    alu_decode u_decode (
        .i_instr  (io.instr),
        .i_rs_val (io.rs_val),
        .i_rt_val (io.rt_val),
        .o_rec    (w_dec)
    );

    assign w_accept = io.in_valid && r_in_ready;

    always_comb begin
        w_m_next       = r_m;
        w_s_next       = r_s;
        w_m_valid_next = r_m_valid;
        w_s_valid_next = r_s_valid;
        if (flush) begin
            w_m_valid_next = 1'b0;
            w_s_valid_next = 1'b0;
        end else if (!r_m_valid || io.out_ready) begin
            // M is free this edge: the older skid entry goes first, a new accept queues behind it.
            if (r_s_valid) begin
                w_m_next       = r_s;
                w_m_valid_next = 1'b1;
                w_s_valid_next = w_accept;
                if (w_accept) w_s_next = w_dec;
            end else begin
                w_m_valid_next = w_accept;
                if (w_accept) w_m_next = w_dec;
            end
        end else if (w_accept) begin
            w_s_next       = w_dec;
            w_s_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m        <= ISSUE_IDLE;
            r_s        <= ISSUE_IDLE;
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_m        <= w_m_next;
            r_s        <= w_s_next;
            r_m_valid  <= w_m_valid_next;
            r_s_valid  <= w_s_valid_next;
            r_in_ready <= !w_s_valid_next;
        end
    end

    assign io.in_ready   = r_in_ready;
    assign io.out_valid  = r_m_valid;
    assign io.r1         = r_m.r1;
    assign io.r2         = r_m.r2;
    assign io.control    = r_m.control;
    assign io.dest       = r_m.dest;
    assign io.we         = r_m.we;
    assign io.mem_rd     = r_m.mem_rd;
    assign io.mem_wr     = r_m.mem_wr;
    assign io.mem_byte   = r_m.mem_byte;
    assign io.store_data = r_m.store_data;
    assign io.branch     = r_m.branch;
    assign io.illegal    = r_m.illegal;
endmodule
